// File: rtl/sdram_arbiter.sv
// Shares the byte-wide sdram port between download, video fetch and the Z80 CPU.
// Fixed priority with a video streak limit so the CPU is not starved by long video runs.
`timescale 1ns/1ps
module sdram_arbiter #(
  parameter int unsigned ACCESS_CYCLES  = 8,
  parameter int unsigned VID_MAX_STREAK = 4
) (
  input  logic        F14M,
  input  logic        RESET_n,
  input  logic        downloading,
  input  logic        dio_req,
  input  logic [24:0] dio_addr,
  input  logic [7:0]  dio_data,
  output logic        dio_ack,
  input  logic        vid_req,
  input  logic [24:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_wait_n,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_din,
  output logic        sdram_we,
  output logic        sdram_oe,
  input  logic [7:0]  sdram_dout,
  output logic        busy
);

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {SRC_DIO, SRC_VID, SRC_CPU} src_t;

  state_t          r_state, w_state;
  src_t            r_src, w_src;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [CW-1:0]   r_streak, w_streak;
  logic [AW-1:0]   r_addr, w_addr;
  logic [DW-1:0]   r_din, w_din;
  logic            r_we, w_we;
  logic            r_oe, w_oe;
  logic            r_dio_ack, w_dio_ack;
  logic            r_vid_valid, w_vid_valid;
  logic            r_cpu_ack, w_cpu_ack;
  logic [DW-1:0]   r_vid_data, w_vid_data;
  logic [DW-1:0]   r_cpu_dout, w_cpu_dout;
  logic            r_busy, w_busy;
  logic            w_cpu_ok;

  assign w_cpu_ok = cpu_req & ~downloading;

  // Grant, access sequencing and completion
  always_comb begin
    w_state     = r_state;
    w_src       = r_src;
    w_cnt       = r_cnt;
    w_streak    = r_streak;
    w_addr      = r_addr;
    w_din       = r_din;
    w_we        = r_we;
    w_oe        = r_oe;
    w_dio_ack   = 1'b0;
    w_vid_valid = 1'b0;
    w_cpu_ack   = 1'b0;
    w_vid_data  = r_vid_data;
    w_cpu_dout  = r_cpu_dout;
    unique case (r_state)
      S_IDLE: begin
        w_we = 1'b0;
        w_oe = 1'b0;
        if (dio_req) begin
          w_src   = SRC_DIO;
          w_addr  = dio_addr;
          w_din   = dio_data;
          w_we    = 1'b1;
          w_cnt   = CW'(ACCESS_CYCLES - 1);
          w_state = S_ACCESS;
        end else if (w_cpu_ok && (r_streak == CW'(VID_MAX_STREAK))) begin
          w_src    = SRC_CPU;
          w_addr   = cpu_addr;
          w_din    = cpu_din;
          w_we     = cpu_we;
          w_oe     = ~cpu_we;
          w_streak = '0;
          w_cnt    = CW'(ACCESS_CYCLES - 1);
          w_state  = S_ACCESS;
        end else if (vid_req) begin
          w_src   = SRC_VID;
          w_addr  = vid_addr;
          w_din   = '0;
          w_oe    = 1'b1;
          w_cnt   = CW'(ACCESS_CYCLES - 1);
          w_state = S_ACCESS;
          // Streak only grows while the CPU is actually being held off
          if (!w_cpu_ok)
            w_streak = '0;
          else if (r_streak < CW'(VID_MAX_STREAK))
            w_streak = r_streak + CW'(1);
        end else if (w_cpu_ok) begin
          w_src    = SRC_CPU;
          w_addr   = cpu_addr;
          w_din    = cpu_din;
          w_we     = cpu_we;
          w_oe     = ~cpu_we;
          w_streak = '0;
          w_cnt    = CW'(ACCESS_CYCLES - 1);
          w_state  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == '0) begin
          w_we    = 1'b0;
          w_oe    = 1'b0;
          w_state = S_DONE;
          case (r_src)
            SRC_DIO: w_dio_ack = 1'b1;
            SRC_VID: begin
              w_vid_valid = 1'b1;
              w_vid_data  = sdram_dout;
            end
            SRC_CPU: begin
              w_cpu_ack = 1'b1;
              if (r_oe) w_cpu_dout = sdram_dout;
            end
            default: ;
          endcase
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge F14M or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state     <= S_IDLE;
      r_src       <= SRC_DIO;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_addr      <= '0;
      r_din       <= '0;
      r_we        <= 1'b0;
      r_oe        <= 1'b0;
      r_dio_ack   <= 1'b0;
      r_vid_valid <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_vid_data  <= '0;
      r_cpu_dout  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_src       <= w_src;
      r_cnt       <= w_cnt;
      r_streak    <= w_streak;
      r_addr      <= w_addr;
      r_din       <= w_din;
      r_we        <= w_we;
      r_oe        <= w_oe;
      r_dio_ack   <= w_dio_ack;
      r_vid_valid <= w_vid_valid;
      r_cpu_ack   <= w_cpu_ack;
      r_vid_data  <= w_vid_data;
      r_cpu_dout  <= w_cpu_dout;
      r_busy      <= w_busy;
    end
  end

  assign sdram_addr = r_addr;
  assign sdram_din  = r_din;
  assign sdram_we   = r_we;
  assign sdram_oe   = r_oe;
  assign dio_ack    = r_dio_ack;
  assign vid_valid  = r_vid_valid;
  assign vid_data   = r_vid_data;
  assign cpu_ack    = r_cpu_ack;
  assign cpu_dout   = r_cpu_dout;
  assign busy       = r_busy;
  assign cpu_wait_n = ~(cpu_req & ~r_cpu_ack);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: scoreboard of expected accesses popped on each ack/valid.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int AC = 8;

  logic        F14M = 1'b0, RESET_n = 1'b0, downloading = 1'b0;
  logic        dio_req = 1'b0, vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [24:0] dio_addr = '0, vid_addr = '0, cpu_addr = '0;
  logic [7:0]  dio_data = '0, cpu_din = '0, sdram_dout = '0;
  logic        dio_ack, vid_valid, cpu_ack, cpu_wait_n, sdram_we, sdram_oe, busy;
  logic [7:0]  vid_data, cpu_dout, sdram_din;
  logic [24:0] sdram_addr;

  sdram_arbiter #(.ACCESS_CYCLES(8), .VID_MAX_STREAK(4)) dut (
    .F14M(F14M), .RESET_n(RESET_n), .downloading(downloading),
    .dio_req(dio_req), .dio_addr(dio_addr), .dio_data(dio_data), .dio_ack(dio_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_we(sdram_we),
    .sdram_oe(sdram_oe), .sdram_dout(sdram_dout), .busy(busy)
  );

  always #5 F14M = ~F14M;

  // Byte memory behind the sdram port, indexed by the low address bits
  logic [7:0] mem [0:4095];
  always @(posedge F14M) begin
    if (sdram_we) mem[sdram_addr[11:0]] <= sdram_din;
    sdram_dout <= mem[sdram_addr[11:0]];
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  src;
    logic        we;
    logic [24:0] addr;
    logic [7:0]  din;
    logic [7:0]  rd;
  } exp_t;
  exp_t sb [$];

  function automatic exp_t mk(input logic [1:0] s, input logic w, input logic [24:0] a,
                              input logic [7:0] d, input logic [7:0] r);
    exp_t e;
    e.src = s; e.we = w; e.addr = a; e.din = d; e.rd = r;
    return e;
  endfunction

  // Bus monitor: captures each strobe window and checks it against the scoreboard on completion
  logic        m_in = 1'b0, m_we;
  logic [24:0] m_addr;
  logic [7:0]  m_din;
  int          m_len = 0, m_unstable = 0;
  int          ack_cnt [3] = '{0, 0, 0};
  logic [1:0]  m_src;
  exp_t        m_exp;

  always @(negedge F14M) begin
    if (sdram_we | sdram_oe) begin
      if (!m_in) begin
        m_in = 1'b1; m_addr = sdram_addr; m_din = sdram_din; m_we = sdram_we;
        m_len = 1; m_unstable = 0;
      end else begin
        m_len++;
        if (sdram_addr !== m_addr || sdram_din !== m_din || sdram_we !== m_we) m_unstable++;
      end
    end else begin
      m_in = 1'b0;
    end
    if (dio_ack | vid_valid | cpu_ack) begin
      check("one_ack", int'(dio_ack) + int'(vid_valid) + int'(cpu_ack), 1);
      m_src = dio_ack ? 2'd0 : (vid_valid ? 2'd1 : 2'd2);
      ack_cnt[m_src]++;
      if (sb.size() == 0) begin
        check("spurious_ack", m_src, 3);
      end else begin
        m_exp = sb.pop_front();
        check("ack_src", m_src, m_exp.src);
        check("acc_addr", m_addr, m_exp.addr);
        check("acc_we", m_we, m_exp.we);
        check("acc_len", m_len, AC);
        check("acc_stable", m_unstable, 0);
        if (m_exp.we) check("acc_din", m_din, m_exp.din);
        else if (m_src == 2'd1) check("vid_data", vid_data, m_exp.rd);
        else check("cpu_dout", cpu_dout, m_exp.rd);
      end
    end
  end

  int t_starts [$];
  int t_we_cyc, t_oe_cyc, t_wlo_cyc, t_ack_c, t_cycles;

  // Raise the requested lines, drop each after its last expected completion, record slot starts
  task automatic run_slots(input int nd, input int nv, input int nc, input int budget);
    int rd, rv, rc, c;
    logic prev;
    rd = nd; rv = nv; rc = nc; c = 0; prev = 1'b0;
    t_starts.delete();
    t_we_cyc = 0; t_oe_cyc = 0; t_wlo_cyc = 0; t_ack_c = -1;
    if (nd > 0) dio_req = 1'b1;
    if (nv > 0) vid_req = 1'b1;
    if (nc > 0) cpu_req = 1'b1;
    while (c < budget) begin
      @(negedge F14M);
      if ((sdram_we | sdram_oe) && !prev) t_starts.push_back(c);
      prev = sdram_we | sdram_oe;
      if (sdram_we) t_we_cyc++;
      if (sdram_oe) t_oe_cyc++;
      if (!cpu_wait_n) t_wlo_cyc++;
      if (dio_ack | vid_valid | cpu_ack) t_ack_c = c;
      if (dio_ack && rd > 0) begin rd--; if (rd == 0) dio_req = 1'b0; end
      if (vid_valid && rv > 0) begin rv--; if (rv == 0) vid_req = 1'b0; end
      if (cpu_ack && rc > 0) begin rc--; if (rc == 0) cpu_req = 1'b0; end
      c++;
      if (rd == 0 && rv == 0 && rc == 0) break;
    end
    t_cycles = c;
    if (rd != 0 || rv != 0 || rc != 0) check("slot_timeout", c, 0);
    @(posedge F14M); #1;
  endtask

  int a0, a1, a2, hi, strb, wcnt;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge F14M);
    check("rst_we", sdram_we, 0);
    check("rst_oe", sdram_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", sdram_addr, 0);
    check("rst_wait_n", cpu_wait_n, 1);
    check("rst_acks", {dio_ack, vid_valid, cpu_ack}, 0);
    @(posedge F14M); #1 RESET_n = 1'b1;

    // Single CPU write
    cpu_we = 1'b1; cpu_addr = 25'h1F800; cpu_din = 8'h41;
    sb.push_back(mk(2'd2, 1'b1, 25'h1F800, 8'h41, 8'h00));
    run_slots(0, 0, 1, 40);
    check("t1_start", t_starts[0], 1);
    check("t1_ack_cycle", t_ack_c, 9);
    check("t1_we_cycles", t_we_cyc, 8);
    check("t1_wait_low", t_wlo_cyc, 9);

    // CPU read back
    cpu_we = 1'b0;
    sb.push_back(mk(2'd2, 1'b0, 25'h1F800, 8'h00, 8'h41));
    run_slots(0, 0, 1, 40);
    check("t2_ack_cycle", t_ack_c, 9);
    check("t2_oe_cycles", t_oe_cyc, 8);
    repeat (5) @(negedge F14M);
    check("t2_dout_held", cpu_dout, 8'h41);
    @(posedge F14M); #1;

    // Simultaneous requests: dio, vid, cpu order, 10-cycle slot period
    dio_addr = 25'h00100; dio_data = 8'hA5; vid_addr = 25'h00100;
    cpu_we = 1'b1; cpu_addr = 25'h00200; cpu_din = 8'h5A;
    a0 = ack_cnt[0]; a1 = ack_cnt[1]; a2 = ack_cnt[2];
    sb.push_back(mk(2'd0, 1'b1, 25'h00100, 8'hA5, 8'h00));
    sb.push_back(mk(2'd1, 1'b0, 25'h00100, 8'h00, 8'hA5));
    sb.push_back(mk(2'd2, 1'b1, 25'h00200, 8'h5A, 8'h00));
    run_slots(1, 1, 1, 80);
    check("t3_start0", t_starts[0], 1);
    check("t3_start1", t_starts[1], 11);
    check("t3_start2", t_starts[2], 21);
    check("t3_dio_acks", ack_cnt[0] - a0, 1);
    check("t3_vid_acks", ack_cnt[1] - a1, 1);
    check("t3_cpu_acks", ack_cnt[2] - a2, 1);

    // Video streak limit lets the CPU in after 4 video slots
    cpu_we = 1'b0; cpu_addr = 25'h00200;
    for (int i = 0; i < 4; i++) sb.push_back(mk(2'd1, 1'b0, 25'h00100, 8'h00, 8'hA5));
    sb.push_back(mk(2'd2, 1'b0, 25'h00200, 8'h00, 8'h5A));
    sb.push_back(mk(2'd1, 1'b0, 25'h00100, 8'h00, 8'hA5));
    run_slots(0, 5, 1, 120);
    check("t4_slots", t_starts.size(), 6);
    check("t4_span", t_starts[5] - t_starts[0], 50);

    // Streak back at zero: video wins over a fresh CPU request again
    sb.push_back(mk(2'd1, 1'b0, 25'h00100, 8'h00, 8'hA5));
    sb.push_back(mk(2'd2, 1'b0, 25'h00200, 8'h00, 8'h5A));
    run_slots(0, 1, 1, 60);
    check("t4b_start1", t_starts[1], 11);

    // Download blocks the CPU while dio writes proceed
    downloading = 1'b1;
    cpu_we = 1'b1; cpu_addr = 25'h00300; cpu_din = 8'h77; cpu_req = 1'b1;
    dio_addr = 25'h00400; dio_data = 8'h11;
    a2 = ack_cnt[2];
    for (int i = 0; i < 3; i++) sb.push_back(mk(2'd0, 1'b1, 25'h00400, 8'h11, 8'h00));
    run_slots(3, 0, 0, 80);
    check("t5_wait_low_dio", t_wlo_cyc, t_cycles);
    hi = 0; strb = 0;
    for (int i = 0; i < 200 - t_cycles; i++) begin
      @(negedge F14M);
      if (cpu_wait_n) hi++;
      if (sdram_we | sdram_oe) strb++;
    end
    check("t5_wait_n_high", hi, 0);
    check("t5_no_grant", strb, 0);
    check("t5_no_cpu_ack", ack_cnt[2] - a2, 0);
    @(posedge F14M); #1 downloading = 1'b0;
    sb.push_back(mk(2'd2, 1'b1, 25'h00300, 8'h77, 8'h00));
    run_slots(0, 0, 1, 40);
    check("t5_cpu_start", t_starts[0], 1);

    // Reset in the third strobe cycle aborts the access silently
    cpu_we = 1'b1; cpu_addr = 25'h00500; cpu_din = 8'h99;
    sb.push_back(mk(2'd2, 1'b1, 25'h00500, 8'h99, 8'h00));
    cpu_req = 1'b1;
    wcnt = 0;
    while (!sdram_we && wcnt < 20) begin @(negedge F14M); wcnt++; end
    check("t6_strobe_seen", sdram_we, 1);
    repeat (2) @(negedge F14M);
    RESET_n = 1'b0;
    #1;
    check("t6_we_drop", sdram_we, 0);
    check("t6_oe_drop", sdram_oe, 0);
    check("t6_busy_drop", busy, 0);
    a2 = ack_cnt[2];
    repeat (3) @(negedge F14M);
    check("t6_no_ack", ack_cnt[2] - a2, 0);
    check("t6_cpu_dout_clr", cpu_dout, 0);
    check("t6_vid_data_clr", vid_data, 0);
    @(posedge F14M); #1 RESET_n = 1'b1;
    run_slots(0, 0, 1, 40);
    check("t6_regrant_start", t_starts[0], 1);
    check("t6_regrant_ack", t_ack_c, 9);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single byte-wide port of the sdram controller between three requesters: ROM/program download (data_io), video fetch, and Z80 CPU.
- Fixed-priority arbitration, with a starvation guard so the CPU gets a slot during long video bursts.
- Sequences each access: holds we/oe, address and data for a fixed number of F14M cycles, captures read data, then returns a one-cycle acknowledge.
- Sits between data_io / VTL_chip / T80se and the sdram block, all in the F14M domain.

Parameters:
- ACCESS_CYCLES, 8: F14M cycles that we/oe stay asserted per access. Legal range 2..15.
- VID_MAX_STREAK, 4: consecutive video grants allowed while a CPU request waits. Legal range 1..15.

Ports:
- F14M  in  1  system clock, 14.77873 MHz.
- RESET_n  in  1  asynchronous, active-low reset.
- downloading  in  1  download active; CPU grants are blocked while high.
- dio_req  in  1  download write request, level.
- dio_addr  in  25  download address.
- dio_data  in  8  download write data.
- dio_ack  out  1  one-cycle pulse when the download write completes.
- vid_req  in  1  video read request, level.
- vid_addr  in  25  video read address.
- vid_data  out  8  video read data, registered.
- vid_valid  out  1  one-cycle pulse; vid_data is valid this cycle and holds until the next video completion.
- cpu_req  in  1  CPU access request, level (derived from MREQ_n & (RD_n|WR_n)).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  25  CPU paged address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data, registered, held until the next CPU read completion.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_wait_n  out  1  drives T80 WAIT_n; equals ~(cpu_req & ~cpu_ack).
- sdram_addr  out  25  to sdram addr.
- sdram_din  out  8  to sdram din.
- sdram_we  out  1  to sdram we.
- sdram_oe  out  1  to sdram oe.
- sdram_dout  in  8  from sdram dout.
- busy  out  1  high in ACCESS and DONE.

Behaviour:
- Reset (RESET_n low, asynchronous): state = IDLE. Cleared to 0: sdram_addr, sdram_din, sdram_we, sdram_oe, all ack/valid outputs, vid_data, cpu_dout, the streak counter and the cycle counter. busy = 0; cpu_wait_n follows its combinational equation.
- Reset mid-access: strobes drop immediately and no ack is issued. The requester must re-request.
- States are IDLE, ACCESS and DONE.
- IDLE, grant evaluated at each rising edge in this priority order:
  1. dio_req: write.
  2. cpu_req, if ~downloading and streak == VID_MAX_STREAK.
  3. vid_req: read.
  4. cpu_req, if ~downloading.
- On a grant, in the same edge:
  - register addr and din from the winner;
  - sdram_we = 1 for a write (dio, or cpu with cpu_we = 1), else sdram_oe = 1;
  - counter = ACCESS_CYCLES-1;
  - go to ACCESS.
  With no grant, stay in IDLE with strobes low.
- Streak counter:
  - video grant while cpu_req & ~downloading: streak increments, saturating at VID_MAX_STREAK;
  - any CPU grant: streak = 0;
  - video grant with no CPU request pending: streak = 0.
- ACCESS: addr, din and strobe are held constant; counter decrements each cycle. When counter == 0, go to DONE.
- DONE (one cycle):
  - we/oe = 0;
  - for a read, sample sdram_dout into vid_data or cpu_dout;
  - pulse the winner's ack/valid for exactly this cycle;
  - go to IDLE.
- Latency: a request seen at IDLE edge k gives strobes asserted for cycles k+1..k+ACCESS_CYCLES and ack high in cycle k+ACCESS_CYCLES+1. Back-to-back slot period is ACCESS_CYCLES+2 cycles.
- Handshake:
  - A requester holds req, addr and data stable until its ack.
  - It must drop req in the cycle after ack; req still high at the next IDLE edge is treated as a new access.
  - req dropped mid-access: the access completes and the ack is still pulsed.
  - req changes during ACCESS have no effect on the current slot.
- Simultaneous requests resolve by priority. Losers keep waiting and are never dropped.
- downloading rising while a CPU access is in ACCESS: that access completes; further CPU grants are blocked, so cpu_wait_n stays low.
- Addresses pass through unchanged; no width conversion.

Test Plan:
1. Reset, then a single CPU write (cpu_addr = 0x1F800, cpu_din = 0x41, ACCESS_CYCLES = 8) -> sdram_we high for exactly 8 cycles with addr 0x1F800 / din 0x41; cpu_ack in cycle 9; cpu_wait_n low for cycles 0..8.
2. CPU read of 0x1F800 with the model returning 0x41 -> sdram_oe high for 8 cycles; cpu_dout = 0x41 when cpu_ack pulses; value held afterwards.
3. dio_req, vid_req and cpu_req all raised in the same cycle -> grant order dio, vid, cpu; slots start 10 cycles apart; exactly one ack per requester.
4. vid_req held continuously, cpu_req pending, VID_MAX_STREAK = 4 -> 4 video slots, then 1 CPU slot, then video resumes; streak counter reset to 0.
5. downloading = 1 with cpu_req high for 200 cycles -> no CPU grant, cpu_wait_n stays low, dio writes proceed. downloading = 0 -> CPU granted at the next IDLE edge.
6. RESET_n pulled low at cycle 3 of an ACCESS -> sdram_we/oe = 0 asynchronously, no ack. After release, the still-asserted request is re-granted with full latency.
